// File: rtl/arq_pkg.sv
// arq_pkg: shared types and helpers for the go-back-N ARQ sender.
// The defaults here are also the parameter defaults of arq_tx.
package arq_pkg;

    localparam int SEQ_W       = 3;
    localparam int PAY_W       = 16;
    localparam int DEF_WINDOW  = 4;
    localparam int DEF_TIMEOUT = 8;

    typedef logic [SEQ_W-1:0] seq_t;

    typedef struct packed {
        seq_t             seq;
        logic [PAY_W-1:0] payload;
    } frame_t;

    // Forward distance from b to a, modulo the sequence space.
    function automatic seq_t seq_dist(input seq_t a, input seq_t b);
        return seq_t'(a - b);
    endfunction

endpackage

// File: rtl/arq_tx_if.sv
// arq_tx_if: arbiter input, link output and ack return bundle of arq_tx.
// The slave view is the sender itself, the master view its environment.
interface arq_tx_if
    import arq_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = PAY_W,
    parameter int SEQ_WIDTH     = SEQ_W,
    parameter int WINDOW        = DEF_WINDOW
);
    logic                     in_valid;
    logic                     in_ready;
    logic [PAYLOAD_WIDTH-1:0] in_payload;
    logic                     out_valid;
    logic                     out_ready;
    logic [SEQ_WIDTH-1:0]     out_seq;
    logic [PAYLOAD_WIDTH-1:0] out_payload;
    logic                     ack_valid;
    logic [SEQ_WIDTH-1:0]     ack_seq;
    logic                     retx_pulse;
    logic [$clog2(WINDOW):0]  outstanding;

    modport master (
        output in_valid, in_payload, out_ready, ack_valid, ack_seq,
        input  in_ready, out_valid, out_seq, out_payload,
        input  retx_pulse, outstanding
    );

    modport slave (
        input  in_valid, in_payload, out_ready, ack_valid, ack_seq,
        output in_ready, out_valid, out_seq, out_payload,
        output retx_pulse, outstanding
    );

endinterface

// File: rtl/arq_retx_timer.sv
// arq_retx_timer: counts cycles without base progress while frames are in flight.
// Saturates at TIMEOUT-1 so expiry stays asserted until the owner clears it.
module arq_retx_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    assign expire = run && (cnt == LAST);

    // Idle or cleared holds zero; otherwise count up and stick at the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arq_tx.sv
// arq_tx: go-back-N ARQ sender with a WINDOW-deep retransmit buffer.
// Tags frames with sequence numbers, frees slots on cumulative acks, rewinds on timeout.
module arq_tx
    import arq_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = PAY_W,
    parameter int WINDOW        = DEF_WINDOW,
    parameter int SEQ_WIDTH     = SEQ_W,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic    clk,
    input  logic    rst,
    arq_tx_if.slave bus
);
    localparam int IW = $clog2(WINDOW);

    typedef logic [SEQ_WIDTH-1:0] ptr_t;

    localparam ptr_t WIN = ptr_t'(WINDOW);

    if ((2 ** SEQ_WIDTH) <= WINDOW) begin : g_bad_seq
        $error("arq_tx: 2**SEQ_WIDTH must exceed WINDOW");
    end
    if ((WINDOW < 2) || ((1 << IW) != WINDOW)) begin : g_bad_window
        $error("arq_tx: WINDOW must be a power of two >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("arq_tx: TIMEOUT must be >= 2");
    end

    logic [PAYLOAD_WIDTH-1:0] buffer [WINDOW];

    ptr_t base, nxt, tail, base_n;
    ptr_t used, in_flight, ack_d;
    logic pending, wait_hs, retx_q;
    logic in_hs, out_vld, out_hs, stall;
    logic ack_ok, expire, fire, tmr_clr;
    logic rewind, set_pend, set_wait, clr_wait;

    assign used      = tail - base;
    assign in_flight = nxt - base;
    assign ack_d     = bus.ack_seq - base;

    assign bus.in_ready = used < WIN;
    assign in_hs        = bus.in_valid && bus.in_ready;

    assign out_vld = (nxt != tail) && !pending;
    assign out_hs  = out_vld && bus.out_ready;
    assign stall   = out_vld && !bus.out_ready;

    assign ack_ok = bus.ack_valid && (ack_d != '0) && (ack_d <= in_flight);
    assign base_n = ack_ok ? bus.ack_seq : base;

    // A same-cycle accepted ack always beats expiry.
    assign fire    = expire && !ack_ok;
    assign tmr_clr = ack_ok || rewind || set_pend;

    assign bus.out_valid   = out_vld;
    assign bus.out_seq     = nxt;
    assign bus.out_payload = buffer[nxt[IW-1:0]];
    assign bus.retx_pulse  = retx_q;
    assign bus.outstanding = used[IW:0];

    arq_retx_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (base != nxt),
        .clear  (tmr_clr),
        .expire (expire)
    );

    // Rewind decision: a held beat is finished first, then one dark cycle, then rewind.
    always_comb begin
        rewind   = 1'b0;
        set_pend = 1'b0;
        set_wait = 1'b0;
        clr_wait = 1'b0;
        if (pending) begin
            rewind = (base_n != nxt);
        end else if (wait_hs) begin
            if (ack_ok) begin
                clr_wait = 1'b1;
            end else if (out_hs) begin
                clr_wait = 1'b1;
                set_pend = 1'b1;
            end
        end else if (fire) begin
            if (stall) begin
                set_wait = 1'b1;
            end else begin
                rewind = 1'b1;
            end
        end
    end

    // Pointer, rewind-pending and retransmit pulse state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base    <= '0;
            nxt     <= '0;
            tail    <= '0;
            pending <= 1'b0;
            wait_hs <= 1'b0;
            retx_q  <= 1'b0;
        end else begin
            base   <= base_n;
            retx_q <= rewind;
            if (in_hs) begin
                tail <= tail + 1'b1;
            end
            if (rewind) begin
                nxt <= base_n;
            end else if (out_hs) begin
                nxt <= nxt + 1'b1;
            end
            if (set_pend) begin
                pending <= 1'b1;
            end else if (pending) begin
                pending <= 1'b0;
            end
            if (set_wait) begin
                wait_hs <= 1'b1;
            end else if (clr_wait) begin
                wait_hs <= 1'b0;
            end
        end
    end

    // Retransmit buffer; no reset needed since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            buffer[tail[IW-1:0]] <= bus.in_payload;
        end
    end

endmodule

// File: tb/tb_arq_tx.sv
// tb_arq_tx: scenario tasks for the go-back-N sender with a frame scoreboard.
// Expected frames are queued on input handshakes and popped on output handshakes.
module tb_arq_tx;
    import arq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    arq_tx_if #(
        .PAYLOAD_WIDTH (PAY_W),
        .SEQ_WIDTH     (SEQ_W),
        .WINDOW        (4)
    ) bus ();

    arq_tx #(
        .PAYLOAD_WIDTH (PAY_W),
        .WINDOW        (4),
        .SEQ_WIDTH     (SEQ_W),
        .TIMEOUT       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_chk = 0;
    int     n_pass = 0;
    int     cyc = 0;
    int     first_hs;
    seq_t   m_tail;
    frame_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_payload = '0;
        bus.out_ready  = 1'b0;
        bus.ack_valid  = 1'b0;
        bus.ack_seq    = '0;
        exp_q.delete();
        m_tail = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic push_exp(input int s, input logic [PAY_W-1:0] p);
        frame_t f;
        f.seq     = seq_t'(s);
        f.payload = p;
        exp_q.push_back(f);
    endtask

    // Push n new frames and drain the scoreboard with out_ready held high.
    task automatic send_frames(input int n, input logic [PAY_W-1:0] pay0);
        frame_t e;
        frame_t f;
        int     pushed = 0;
        int     guard = 0;
        first_hs = -1;
        bus.out_ready = 1'b1;
        while ((pushed < n || exp_q.size() != 0) && guard < 200) begin
            bus.in_valid   = (pushed < n);
            bus.in_payload = pay0 + PAY_W'(pushed);
            if (bus.out_valid === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL send_extra: got seq %0d pay %h, want none",
                             bus.out_seq, bus.out_payload);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_seq !== e.seq || bus.out_payload !== e.payload)
                        $display("FAIL send_frame: got seq %0d pay %h, want seq %0d pay %h",
                                 bus.out_seq, bus.out_payload, e.seq, e.payload);
                    else
                        n_pass++;
                end
                if (first_hs < 0) first_hs = cyc + 1;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                f.seq     = m_tail;
                f.payload = bus.in_payload;
                exp_q.push_back(f);
                m_tail++;
                pushed++;
            end
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
        if (guard >= 200) begin
            n_chk++;
            $display("FAIL send_budget: got %0d pending frames, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        else n_pass++;
        n_chk++;
        if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
        n_chk++;
        if (bus.retx_pulse !== 1'b0) $display("FAIL rst_retx: got %b want 0", bus.retx_pulse);
        else n_pass++;
        n_chk++;
        if (bus.outstanding !== 3'd0) $display("FAIL rst_outstanding: got %0d want 0", bus.outstanding);
        else n_pass++;
        n_chk++;
        if (bus.out_seq !== 3'd0) $display("FAIL rst_out_seq: got %0d want 0", bus.out_seq);
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        send_frames(4, 16'h00A0);
        n_chk++;
        if (bus.in_ready !== 1'b0) $display("FAIL basic_full_ready: got %b want 0", bus.in_ready);
        else n_pass++;
        n_chk++;
        if (bus.outstanding !== 3'd4) $display("FAIL basic_full_out: got %0d want 4", bus.outstanding);
        else n_pass++;
        bus.ack_valid = 1'b1;
        bus.ack_seq   = 3'd4;
        tick();
        bus.ack_valid = 1'b0;
        n_chk++;
        if (bus.outstanding !== 3'd0) $display("FAIL basic_ack_out: got %0d want 0", bus.outstanding);
        else n_pass++;
        n_chk++;
        if (bus.in_ready !== 1'b1) $display("FAIL basic_ack_ready: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_partial_ack();
        logic [SEQ_W-1:0] acks [5];
        logic [2:0]       want [5];
        int               retx_seen = 0;
        acks = '{3'd2, 3'd2, 3'd1, 3'd5, 3'd4};
        want = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
        do_reset();
        send_frames(4, 16'h00B0);
        for (int i = 0; i < 5; i++) begin
            bus.ack_valid = 1'b1;
            bus.ack_seq   = acks[i];
            tick();
            if (bus.retx_pulse === 1'b1) retx_seen++;
            n_chk++;
            if (bus.outstanding !== want[i])
                $display("FAIL partial_ack%0d: got %0d want %0d", i, bus.outstanding, want[i]);
            else
                n_pass++;
        end
        bus.ack_valid = 1'b0;
        n_chk++;
        if (retx_seen !== 0) $display("FAIL partial_retx: got %0d pulses want 0", retx_seen);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int t0;
        do_reset();
        send_frames(3, 16'h00C0);
        t0 = first_hs;
        while (bus.retx_pulse !== 1'b1 && cyc < t0 + 20) tick();
        n_chk++;
        if (cyc !== t0 + 8) $display("FAIL timeout_cycle: got %0d want %0d", cyc - t0, 8);
        else n_pass++;
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_seq !== 3'd0)
            $display("FAIL timeout_restart: got valid %b seq %0d, want valid 1 seq 0",
                     bus.out_valid, bus.out_seq);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) push_exp(i, 16'h00C0 + PAY_W'(i));
        send_frames(0, '0);
    endtask

    task automatic test_ack_collision();
        int t0;
        do_reset();
        send_frames(2, 16'h00D0);
        t0 = first_hs;
        while (cyc < t0 + 7) tick();
        bus.ack_valid = 1'b1;
        bus.ack_seq   = 3'd1;
        tick();
        bus.ack_valid = 1'b0;
        n_chk++;
        if (bus.retx_pulse !== 1'b0) $display("FAIL coll_retx: got %b want 0", bus.retx_pulse);
        else n_pass++;
        n_chk++;
        if (bus.outstanding !== 3'd1) $display("FAIL coll_out: got %0d want 1", bus.outstanding);
        else n_pass++;
        while (bus.retx_pulse !== 1'b1 && cyc < t0 + 30) tick();
        n_chk++;
        if (cyc !== t0 + 16) $display("FAIL coll_restart: got %0d want %0d", cyc - t0, 16);
        else n_pass++;
        push_exp(1, 16'h00D1);
        send_frames(0, '0);
    endtask

    task automatic test_wrap();
        frame_t e;
        frame_t f;
        int     pushed = 0;
        int     got = 0;
        int     guard = 0;
        int     bad = 0;
        int     retx_seen = 0;
        int     seq_bad = 0;
        logic   ack_due = 1'b0;
        seq_t   ack_val = '0;
        seq_t   m_base = '0;
        do_reset();
        bus.out_ready = 1'b1;
        while (got < 20 && guard < 200) begin
            if (bus.outstanding !== 3'(seq_dist(m_tail, m_base))) bad++;
            bus.in_valid   = (pushed < 20);
            bus.in_payload = 16'h0100 + PAY_W'(pushed);
            bus.ack_valid  = ack_due;
            bus.ack_seq    = ack_val;
            if (ack_due) m_base = ack_val;
            ack_due = 1'b0;
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                if (bus.out_seq !== e.seq || bus.out_payload !== e.payload) seq_bad++;
                ack_due = 1'b1;
                ack_val = seq_t'(e.seq + 1'b1);
                got++;
            end
            if (bus.retx_pulse === 1'b1) retx_seen++;
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                f.seq     = m_tail;
                f.payload = bus.in_payload;
                exp_q.push_back(f);
                m_tail++;
                pushed++;
            end
            tick();
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.ack_valid = ack_due;
        bus.ack_seq   = ack_val;
        tick();
        bus.ack_valid = 1'b0;
        n_chk++;
        if (got !== 20) $display("FAIL wrap_count: got %0d frames want 20", got);
        else n_pass++;
        n_chk++;
        if (seq_bad !== 0) $display("FAIL wrap_frames: got %0d wrong frames want 0", seq_bad);
        else n_pass++;
        n_chk++;
        if (bad !== 0) $display("FAIL wrap_outstanding: got %0d wrong cycles want 0", bad);
        else n_pass++;
        n_chk++;
        if (retx_seen !== 0) $display("FAIL wrap_retx: got %0d pulses want 0", retx_seen);
        else n_pass++;
        n_chk++;
        if (bus.outstanding !== 3'd0) $display("FAIL wrap_final: got %0d want 0", bus.outstanding);
        else n_pass++;
    endtask

    task automatic test_stall_reset();
        frame_t e;
        int     t0;
        int     bad = 0;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_payload = 16'h00E0 + PAY_W'(i);
            push_exp(i, bus.in_payload);
            m_tail++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_seq !== e.seq || bus.out_payload !== e.payload)
            $display("FAIL stall_first: got v %b seq %0d pay %h, want v 1 seq %0d pay %h",
                     bus.out_valid, bus.out_seq, bus.out_payload, e.seq, e.payload);
        else
            n_pass++;
        t0 = cyc + 1;
        tick();
        bus.out_ready = 1'b0;
        while (cyc < t0 + 12) begin
            if (bus.out_valid !== 1'b1 || bus.out_seq !== 3'd1 ||
                bus.out_payload !== 16'h00E1 || bus.retx_pulse !== 1'b0) bad++;
            tick();
        end
        n_chk++;
        if (bad !== 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
        else n_pass++;
        bus.out_ready = 1'b1;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_seq !== e.seq || bus.out_payload !== e.payload)
            $display("FAIL stall_release: got v %b seq %0d pay %h, want v 1 seq %0d pay %h",
                     bus.out_valid, bus.out_seq, bus.out_payload, e.seq, e.payload);
        else
            n_pass++;
        tick();
        bus.out_ready = 1'b0;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.retx_pulse !== 1'b0)
            $display("FAIL stall_pending: got v %b retx %b, want v 0 retx 0",
                     bus.out_valid, bus.retx_pulse);
        else
            n_pass++;
        tick();
        n_chk++;
        if (bus.retx_pulse !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_seq !== 3'd0)
            $display("FAIL stall_rewind: got retx %b v %b seq %0d, want retx 1 v 1 seq 0",
                     bus.retx_pulse, bus.out_valid, bus.out_seq);
        else
            n_pass++;
        exp_q.delete();
        push_exp(0, 16'h00E0);
        send_frames(0, '0);
        bus.out_ready = 1'b0;
        n_chk++;
        if (bus.outstanding !== 3'd3 || bus.out_valid !== 1'b1 || bus.out_seq !== 3'd1)
            $display("FAIL premid_state: got out %0d v %b seq %0d, want out 3 v 1 seq 1",
                     bus.outstanding, bus.out_valid, bus.out_seq);
        else
            n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.outstanding !== 3'd0 ||
            bus.out_seq !== 3'd0 || bus.in_ready !== 1'b1)
            $display("FAIL midrst_state: got v %b out %0d seq %0d rdy %b, want v 0 out 0 seq 0 rdy 1",
                     bus.out_valid, bus.outstanding, bus.out_seq, bus.in_ready);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_partial_ack();
        test_timeout();
        test_ack_collision();
        test_wrap();
        test_stall_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
